cc_miss_req_unit: RTL and testbench
===================================

# cc_miss_req_unit

Cache-controller miss request stage that sits directly upstream of the data fill unit. It accepts a miss from the tag-compare stage and records the miss address in the miss address FIFO that the fill unit pops. It then issues one critical-word-first AXI WRAP read burst (8 beats × 64 bit = one 64-byte line) on the AR channel. An outstanding-burst counter, decremented by the fill unit's FIFO pop, bounds how many line fills are in flight.

## Interface
Parameters:
- MAX_OUTSTANDING, default 1: maximum AR bursts issued but not yet filled; legal values 1..7.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- miss_i  input  1  miss request from tag compare; held until acknowledged.
- miss_addr_i  input  32  byte address of the missing access.
- miss_ack_o  output  1  request accepted this cycle.
- miss_addr_fifo_full_i  input  1  miss address FIFO full.
- miss_addr_fifo_wren_o  output  1  push strobe to the miss address FIFO.
- miss_addr_fifo_wdata_o  output  32  address pushed, equal to miss_addr_i unmodified.
- fill_done_i  input  1  pulse when the fill unit pops the FIFO (line written).
- mem_arid_o  output  4  constant 0.
- mem_araddr_o  output  32  {addr[31:3], 3'b000}.
- mem_arlen_o  output  4  constant 7.
- mem_arsize_o  output  3  constant 3 (8 bytes).
- mem_arburst_o  output  2  constant 2'b10 (WRAP).
- mem_arvalid_o  output  1  AR valid.
- mem_arready_i  input  1  AR ready.
- busy_o  output  1  state != S_IDLE or outstanding != 0.

## Operation
- The FSM has two states, S_IDLE and S_REQ. Registers: state, araddr (32 bit), outstanding counter (3 bit).
- **S_IDLE acceptance:** a miss is accepted when miss_i && !miss_addr_fifo_full_i && outstanding < MAX_OUTSTANDING.
  - miss_ack_o = 1 and miss_addr_fifo_wren_o = 1, both combinational in the same cycle.
  - araddr <= {miss_addr_i[31:3], 3'b000}.
  - state <= S_REQ.
- **S_REQ:**
  - mem_arvalid_o = 1 (registered state decode).
  - mem_araddr_o holds stable while arvalid is high.
  - On mem_arready_i: outstanding increments, state <= S_IDLE.
  - No new miss is accepted in S_REQ.
- **Outstanding counter:**
  - +1 on an AR handshake; −1 on fill_done_i.
  - Both in the same cycle: the counter is unchanged.
  - fill_done_i when the counter is 0 and no handshake occurs: ignored, the counter stays 0 (no underflow).
- **Blocking:**
  - FIFO full or outstanding == MAX_OUTSTANDING: the miss waits, miss_ack_o = 0.
  - An acceptance cycle never has wren high while full is high.
- **Wrap addressing:** beat k of the burst returns line offset (addr[5:3] + k) mod 8. This matches the fill unit's write pointer, which starts at addr[5:3].
- **Constant outputs** (arid, arlen, arsize, arburst) are driven constant, including during reset.

## Timing
- Reset values: state S_IDLE, outstanding 0, araddr 0.
  - miss_ack_o, miss_addr_fifo_wren_o, mem_arvalid_o and busy_o are all 0.
  - mem_araddr_o = 0.
- Miss accepted in cycle T → mem_arvalid_o high from T+1.
- With arready held high: handshake at T+1, counter updated at T+2, S_IDLE at T+2.
- Next miss acceptance:
  - earliest at T+2 when MAX_OUTSTANDING > 1;
  - when MAX_OUTSTANDING = 1, earliest in the cycle after the fill_done_i that brings the counter to 0.
- The AXI rule applies: once asserted, arvalid stays high until arready, with no combinational path from arready to arvalid.
- Reset asserted mid-S_REQ: arvalid is 0 in the next cycle and the counter clears. The FIFO is reset by its owner in the same cycle.

## Structure
- Shared package cc_pkg holds:
  - AXI_BURST_WRAP = 2'b10, AXI_SIZE_8B = 3'd3, LINE_BEATS = 8, AXI_LEN_LINE = 4'd7;
  - the address field widths TAG_W = 17, INDEX_W = 9, OFFSET_W = 6;
  - the state enum typedef for this FSM.
- The fill unit uses the same package constants.
- No sub-module: the FSM and counter fit in one module of about 150 lines.

## Test plan
- **Single miss:** miss_addr_i = 0x0001_2368, arready high → ack and wren at T, wdata 0x0001_2368, araddr 0x0001_2368, arlen 7, arburst 2'b10, arvalid only at T+1, busy_o 1 until fill_done_i.
- **AR backpressure:** arready low for 5 cycles → arvalid stays 1 and araddr stays stable; handshake on the 6th cycle; counter becomes 1 the cycle after.
- **Outstanding limit with MAX_OUTSTANDING = 1:** second miss pending → no ack until fill_done_i; ack occurs in the cycle after the counter reaches 0.
- **FIFO full:** miss_i high with full high for 3 cycles → no ack, no wren, arvalid 0; acceptance in the first cycle full drops.
- **Simultaneous events with MAX_OUTSTANDING = 2, counter 1:** AR handshake and fill_done_i in the same cycle → counter stays 1. fill_done_i with counter 0 → counter stays 0.
- **Reset mid-request:** rst in S_REQ → arvalid 0, busy_o 0 next cycle; a following miss is accepted normally.

Source files
------------

// File: rtl/cc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cc_pkg
// Description : Shared cache-controller constants and types. Used by the miss
//               request stage and the data fill unit so both sides agree on
//               line geometry and AXI burst encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cc_pkg;

    // AXI burst encoding for one 64-byte line fetched as 8 x 64-bit beats
    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
    localparam int         LINE_BEATS     = 8;
    localparam logic [3:0] AXI_LEN_LINE   = 4'd7;
    localparam logic [3:0] AXI_ID_MISS    = 4'd0;

    // 32-bit byte address split: tag | index | line offset
    localparam int TAG_W    = 17;
    localparam int INDEX_W  = 9;
    localparam int OFFSET_W = 6;

    // Miss request FSM
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } miss_req_state_t;

endpackage : cc_pkg
`default_nettype wire

// File: rtl/cc_miss_req_unit.sv
`default_nettype none
// ============================================================================
// Module      : cc_miss_req_unit
// Description : Miss request stage. Accepts a miss from tag compare, pushes
//               the miss address into the fill unit's miss address FIFO and
//               issues one critical-word-first AXI WRAP burst (8 x 64 bit) on
//               the AR channel. An outstanding-burst counter, decremented by
//               the fill unit's FIFO pop, limits the number of fills in flight.
// Ports       : clk, rst                  - clock / sync active-high reset
//               miss_i, miss_addr_i       - miss request (held until ack)
//               miss_ack_o                - miss accepted this cycle
//               miss_addr_fifo_*          - push side of miss address FIFO
//               fill_done_i               - fill unit popped the FIFO
//               mem_ar*                   - AXI read address channel
//               busy_o                    - request pending or fills in flight
// Revision    : 1.0 - initial release
// ============================================================================
module cc_miss_req_unit
    import cc_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_i,
    input  logic [31:0] miss_addr_i,
    output logic        miss_ack_o,
    input  logic        miss_addr_fifo_full_i,
    output logic        miss_addr_fifo_wren_o,
    output logic [31:0] miss_addr_fifo_wdata_o,
    input  logic        fill_done_i,
    output logic [3:0]  mem_arid_o,
    output logic [31:0] mem_araddr_o,
    output logic [3:0]  mem_arlen_o,
    output logic [2:0]  mem_arsize_o,
    output logic [1:0]  mem_arburst_o,
    output logic        mem_arvalid_o,
    input  logic        mem_arready_i,
    output logic        busy_o
);

    localparam logic [2:0] c_max_outstanding = 3'(MAX_OUTSTANDING);

    miss_req_state_t r_state;
    miss_req_state_t w_state_next;
    logic [31:0]     r_araddr;
    logic [2:0]      r_outstanding;
    logic            w_accept;
    logic            w_ar_hs;

    // Acceptance is only possible from idle with FIFO room and fill budget.
    // Gating with rst keeps ack/wren low while reset is held.
    assign w_accept = !rst && (r_state == S_IDLE) && miss_i &&
                      !miss_addr_fifo_full_i &&
                      (r_outstanding < c_max_outstanding);

    // arvalid is a pure state decode, so arready never reaches it combinationally
    assign w_ar_hs = mem_arvalid_o && mem_arready_i;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept)      w_state_next = S_REQ;
            S_REQ:   if (mem_arready_i) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        miss_ack_o            = 1'b0;
        miss_addr_fifo_wren_o = 1'b0;
        mem_arvalid_o         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                miss_ack_o            = w_accept;
                miss_addr_fifo_wren_o = w_accept;
            end
            S_REQ: begin
                mem_arvalid_o = 1'b1;
            end
            default: begin
                mem_arvalid_o = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // AR address: captured at acceptance, stable for the whole S_REQ period.
    // Aligned to the 64-bit beat; the WRAP burst starts at the critical word
    // (addr[5:3]) and wraps inside the 64-byte line.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_araddr <= 32'd0;
        end else if (w_accept) begin
            r_araddr <= {miss_addr_i[31:3], 3'b000};
        end
    end

    // ------------------------------------------------------------------------
    // Outstanding bursts: +1 on AR handshake, -1 on fill pop. A pop with no
    // bursts in flight is ignored rather than wrapping the counter.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= 3'd0;
        end else begin
            unique case ({w_ar_hs, fill_done_i})
                2'b10:   r_outstanding <= r_outstanding + 3'd1;
                2'b01:   if (r_outstanding != 3'd0) r_outstanding <= r_outstanding - 3'd1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign miss_addr_fifo_wdata_o = miss_addr_i;
    assign mem_araddr_o           = r_araddr;
    assign mem_arid_o             = AXI_ID_MISS;
    assign mem_arlen_o            = AXI_LEN_LINE;
    assign mem_arsize_o           = AXI_SIZE_8B;
    assign mem_arburst_o          = AXI_BURST_WRAP;
    assign busy_o                 = (r_state != S_IDLE) || (r_outstanding != 3'd0);

endmodule : cc_miss_req_unit
`default_nettype wire

// File: tb/tb_cc_miss_req_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cc_miss_req_unit
// Description : Directed self-checking bench. Instance a uses
//               MAX_OUTSTANDING = 1, instance b uses MAX_OUTSTANDING = 2.
//               Inputs change 1 time unit after the rising edge; outputs are
//               sampled 1 time unit later, well before the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cc_miss_req_unit;

    logic clk;
    logic rst;

    // instance a (MAX_OUTSTANDING = 1)
    logic        miss_a, full_a, fill_a, arready_a;
    logic [31:0] addr_a;
    logic        ack_a, wren_a, arvalid_a, busy_a;
    logic [31:0] wdata_a, araddr_a;
    logic [3:0]  arid_a, arlen_a;
    logic [2:0]  arsize_a;
    logic [1:0]  arburst_a;

    // instance b (MAX_OUTSTANDING = 2)
    logic        miss_b, full_b, fill_b, arready_b;
    logic [31:0] addr_b;
    logic        ack_b, wren_b, arvalid_b, busy_b;
    logic [31:0] wdata_b, araddr_b;
    logic [3:0]  arid_b, arlen_b;
    logic [2:0]  arsize_b;
    logic [1:0]  arburst_b;

    int checks   = 0;
    int failures = 0;

    cc_miss_req_unit #(.MAX_OUTSTANDING(1)) u_dut_a (
        .clk                    (clk),
        .rst                    (rst),
        .miss_i                 (miss_a),
        .miss_addr_i            (addr_a),
        .miss_ack_o             (ack_a),
        .miss_addr_fifo_full_i  (full_a),
        .miss_addr_fifo_wren_o  (wren_a),
        .miss_addr_fifo_wdata_o (wdata_a),
        .fill_done_i            (fill_a),
        .mem_arid_o             (arid_a),
        .mem_araddr_o           (araddr_a),
        .mem_arlen_o            (arlen_a),
        .mem_arsize_o           (arsize_a),
        .mem_arburst_o          (arburst_a),
        .mem_arvalid_o          (arvalid_a),
        .mem_arready_i          (arready_a),
        .busy_o                 (busy_a)
    );

    cc_miss_req_unit #(.MAX_OUTSTANDING(2)) u_dut_b (
        .clk                    (clk),
        .rst                    (rst),
        .miss_i                 (miss_b),
        .miss_addr_i            (addr_b),
        .miss_ack_o             (ack_b),
        .miss_addr_fifo_full_i  (full_b),
        .miss_addr_fifo_wren_o  (wren_b),
        .miss_addr_fifo_wdata_o (wdata_b),
        .fill_done_i            (fill_b),
        .mem_arid_o             (arid_b),
        .mem_araddr_o           (araddr_b),
        .mem_arlen_o            (arlen_b),
        .mem_arsize_o           (arsize_b),
        .mem_arburst_o          (arburst_b),
        .mem_arvalid_o          (arvalid_b),
        .mem_arready_i          (arready_b),
        .busy_o                 (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // let combinational outputs settle after an input change
    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        miss_a = 1'b0; full_a = 1'b0; fill_a = 1'b0; arready_a = 1'b0; addr_a = 32'd0;
        miss_b = 1'b0; full_b = 1'b0; fill_b = 1'b0; arready_b = 1'b0; addr_b = 32'd0;
        tick();
        tick();

        // ---------------- reset state ----------------
        settle();
        chk("rst_ack",     32'(ack_a),     32'd0);
        chk("rst_wren",    32'(wren_a),    32'd0);
        chk("rst_arvalid", 32'(arvalid_a), 32'd0);
        chk("rst_busy",    32'(busy_a),    32'd0);
        chk("rst_araddr",  araddr_a,       32'd0);
        chk("rst_arid",    32'(arid_a),    32'd0);
        chk("rst_arlen",   32'(arlen_a),   32'd7);
        chk("rst_arsize",  32'(arsize_a),  32'd3);
        chk("rst_arburst", 32'(arburst_a), 32'd2);
        // a miss presented during reset must not be acknowledged
        miss_a = 1'b1; addr_a = 32'h0000_1000;
        settle();
        chk("rst_ack_miss", 32'(ack_a), 32'd0);
        miss_a = 1'b0;
        tick();
        rst = 1'b0;

        // ---------------- single miss (instance a) ----------------
        miss_a = 1'b1; addr_a = 32'h0001_2368; arready_a = 1'b1;
        settle();
        chk("single_ack_T",     32'(ack_a),     32'd1);
        chk("single_wren_T",    32'(wren_a),    32'd1);
        chk("single_wdata_T",   wdata_a,        32'h0001_2368);
        chk("single_arvalid_T", 32'(arvalid_a), 32'd0);
        tick();
        miss_a = 1'b0;
        settle();
        chk("single_arvalid_T1", 32'(arvalid_a), 32'd1);
        chk("single_araddr_T1",  araddr_a,       32'h0001_2368);
        chk("single_arlen_T1",   32'(arlen_a),   32'd7);
        chk("single_arburst_T1", 32'(arburst_a), 32'd2);
        chk("single_ack_T1",     32'(ack_a),     32'd0);
        chk("single_busy_T1",    32'(busy_a),    32'd1);
        tick();
        settle();
        chk("single_arvalid_T2", 32'(arvalid_a), 32'd0);
        chk("single_busy_T2",    32'(busy_a),    32'd1);

        // ---------------- outstanding limit, MAX = 1 ----------------
        miss_a = 1'b1; addr_a = 32'h1000_0004; arready_a = 1'b0;
        settle();
        chk("limit_ack_blocked0", 32'(ack_a),  32'd0);
        chk("limit_wren_blocked", 32'(wren_a), 32'd0);
        tick();
        chk("limit_ack_blocked1", 32'(ack_a),  32'd0);
        fill_a = 1'b1;
        settle();
        chk("limit_ack_fill_cycle", 32'(ack_a), 32'd0);
        tick();
        fill_a = 1'b0;
        settle();
        chk("limit_busy_after_fill", 32'(busy_a), 32'd0);
        chk("limit_ack_after_fill",  32'(ack_a),  32'd1);
        chk("limit_wdata",           wdata_a,     32'h1000_0004);
        tick();
        miss_a = 1'b0;

        // ---------------- AR backpressure ----------------
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp_arvalid_held", 32'(arvalid_a), 32'd1);
            chk("bp_araddr_stable", araddr_a,      32'h1000_0000);
            tick();
        end
        arready_a = 1'b1;
        settle();
        chk("bp_arvalid_hs", 32'(arvalid_a), 32'd1);
        tick();
        arready_a = 1'b0;
        settle();
        chk("bp_arvalid_after", 32'(arvalid_a), 32'd0);
        chk("bp_busy_cnt1",     32'(busy_a),    32'd1);
        fill_a = 1'b1;
        tick();
        fill_a = 1'b0;
        settle();
        chk("bp_busy_drained", 32'(busy_a), 32'd0);

        // ---------------- FIFO full ----------------
        full_a = 1'b1; miss_a = 1'b1; addr_a = 32'h0000_0ABC;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("full_ack",     32'(ack_a),     32'd0);
            chk("full_wren",    32'(wren_a),    32'd0);
            chk("full_arvalid", 32'(arvalid_a), 32'd0);
            tick();
        end
        full_a = 1'b0;
        settle();
        chk("full_drop_ack",  32'(ack_a),  32'd1);
        chk("full_drop_wren", 32'(wren_a), 32'd1);
        tick();
        miss_a = 1'b0; arready_a = 1'b1;
        settle();
        chk("full_arvalid_T1", 32'(arvalid_a), 32'd1);
        chk("full_araddr_T1",  araddr_a,       32'h0000_0AB8);
        tick();
        arready_a = 1'b0;
        fill_a = 1'b1;
        tick();
        fill_a = 1'b0;

        // ---------------- reset mid-request ----------------
        miss_a = 1'b1; addr_a = 32'h2222_2220;
        settle();
        chk("rstreq_ack", 32'(ack_a), 32'd1);
        tick();
        miss_a = 1'b0;
        settle();
        chk("rstreq_arvalid_req", 32'(arvalid_a), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("rstreq_arvalid", 32'(arvalid_a), 32'd0);
        chk("rstreq_busy",    32'(busy_a),    32'd0);
        chk("rstreq_araddr",  araddr_a,       32'd0);
        miss_a = 1'b1; addr_a = 32'h3333_3338; arready_a = 1'b1;
        settle();
        chk("rstreq_next_ack", 32'(ack_a), 32'd1);
        tick();
        miss_a = 1'b0;
        settle();
        chk("rstreq_next_arvalid", 32'(arvalid_a), 32'd1);
        chk("rstreq_next_araddr",  araddr_a,       32'h3333_3338);
        tick();
        arready_a = 1'b0;

        // ---------------- MAX = 2: overlap and simultaneous events ----------------
        arready_b = 1'b1;
        miss_b = 1'b1; addr_b = 32'h0000_0040;
        settle();
        chk("m2_ack_first", 32'(ack_b), 32'd1);
        tick();
        miss_b = 1'b0;
        settle();
        chk("m2_arvalid_first", 32'(arvalid_b), 32'd1);
        tick();                                   // handshake -> counter 1
        miss_b = 1'b1; addr_b = 32'h0000_0080;
        settle();
        chk("m2_ack_T2", 32'(ack_b), 32'd1);      // earliest re-accept at T+2
        tick();
        miss_b = 1'b0; fill_b = 1'b1;
        settle();
        chk("m2_arvalid_second", 32'(arvalid_b), 32'd1);
        tick();                                   // handshake + fill -> counter stays 1
        fill_b = 1'b0;
        miss_b = 1'b1; addr_b = 32'h0000_00C0;
        settle();
        chk("m2_ack_third", 32'(ack_b), 32'd1);   // counter 1 < 2
        tick();
        miss_b = 1'b0;
        settle();
        chk("m2_araddr_third", araddr_b, 32'h0000_00C0);
        tick();                                   // handshake -> counter 2
        miss_b = 1'b1; addr_b = 32'h0000_0100;
        settle();
        chk("m2_ack_at_limit0", 32'(ack_b), 32'd0);
        tick();
        chk("m2_ack_at_limit1", 32'(ack_b), 32'd0);
        miss_b = 1'b0; fill_b = 1'b1;
        tick();                                   // counter 1
        settle();
        chk("m2_busy_cnt1", 32'(busy_b), 32'd1);
        tick();                                   // counter 0
        fill_b = 1'b0;
        settle();
        chk("m2_busy_cnt0", 32'(busy_b), 32'd0);
        fill_b = 1'b1;
        tick();                                   // pop at zero is ignored
        fill_b = 1'b0;
        settle();
        chk("m2_busy_no_underflow", 32'(busy_b), 32'd0);
        miss_b = 1'b1; addr_b = 32'h0000_0148;
        settle();
        chk("m2_ack_after_underflow", 32'(ack_b), 32'd1);
        tick();
        miss_b = 1'b0;
        settle();
        chk("m2_araddr_last", araddr_b, 32'h0000_0148);
        tick();
        arready_b = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cc_miss_req_unit
`default_nettype wire
